// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three sides of the shared data-memory port:
//     ls_*   pipeline load/store requester (req/we/addr/wdata in, gnt/rvalid/rdata out)
//     io_*   I/O-side requester (loader / UART DMA), same signal set
//     mem_*  BRAM port (en/we/addr/wdata toward memory, rdata back)
//     stall_mem  pipeline freeze request
//   Modports:
//     slave  - the arbiter
//     master - the surrounding system (requesters and BRAM)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 64
);
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   logic              io_req;
   logic              io_we;
   logic [ADDR_W-1:0] io_addr;
   logic [DATA_W-1:0] io_wdata;
   logic              io_gnt;
   logic              io_rvalid;
   logic [DATA_W-1:0] io_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_mem;

   modport slave (
      input  ls_req, ls_we, ls_addr, ls_wdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      input  io_req, io_we, io_addr, io_wdata,
      output io_gnt, io_rvalid, io_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output stall_mem
   );

   modport master (
      output ls_req, ls_we, ls_addr, ls_wdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      output io_req, io_we, io_addr, io_wdata,
      input  io_gnt, io_rvalid, io_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  stall_mem
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single BRAM data port between the pipeline load/store path
//   and the I/O requester. One grant per cycle, combinational in the request
//   cycle. Granted reads are tagged with their owner and the read data is
//   steered back to that owner LOAD_LATENCY cycles later. stall_mem freezes
//   the pipeline whenever its request is not granted.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous, active-high reset; also blanks all outputs while high
//     bus  - mem_port_arbiter_if.slave (ls_*, io_*, mem_*, stall_mem)
//
//   Configuration macro MEM_ARB_FAIR_EN:
//     defined   - starve counter forces an I/O grant after STARVE_LIMIT
//                 consecutive denied I/O cycles
//     undefined - strict pipeline priority, STARVE_LIMIT has no effect
module mem_port_arbiter #(
   parameter int LOAD_LATENCY = 1,
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 8
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.slave  bus
);

   if (LOAD_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_param
      $error("mem_port_arbiter: LOAD_LATENCY and STARVE_LIMIT must be >= 1");
   end

   logic              sel_ls;
   logic              sel_io;
   logic              force_io;
   logic              read_issue;
   logic              out_ls_valid;
   logic              out_io_valid;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;
   logic              we_sel;

   // Read tag pipeline: stage 0 holds the read granted last cycle, the last
   // stage lines up with mem_rdata. Owner bit: 0 = pipeline, 1 = I/O.
   logic [LOAD_LATENCY-1:0] tag_v;
   logic [LOAD_LATENCY-1:0] tag_own;

`ifdef MEM_ARB_FAIR_EN
   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;

   assign force_io = (starve_cnt == CNT_MAX);

   // Counts consecutive cycles I/O waited; any break in the I/O request or
   // an I/O grant restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!bus.io_req || sel_io) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign force_io = 1'b0;
`endif

   // Pipeline wins by default; I/O wins alone or when it has starved.
   always_comb begin
      sel_ls = 1'b0;
      sel_io = 1'b0;
      if (!rst) begin
         if (bus.ls_req && !(bus.io_req && force_io)) begin
            sel_ls = 1'b1;
         end else if (bus.io_req) begin
            sel_io = 1'b1;
         end
      end
   end

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      we_sel    = 1'b0;
      if (sel_ls) begin
         addr_sel  = bus.ls_addr;
         wdata_sel = bus.ls_wdata;
         we_sel    = bus.ls_we;
      end else if (sel_io) begin
         addr_sel  = bus.io_addr;
         wdata_sel = bus.io_wdata;
         we_sel    = bus.io_we;
      end
   end

   assign read_issue = (sel_ls && !bus.ls_we) || (sel_io && !bus.io_we);

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v   <= '0;
         tag_own <= '0;
      end else begin
         tag_v[0]   <= read_issue;
         tag_own[0] <= sel_io;
         for (int i = 1; i < LOAD_LATENCY; i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_own[i] <= tag_own[i-1];
         end
      end
   end

   // rst gating covers the first reset cycle, before the synchronous clear
   // of the tag pipeline has taken effect.
   assign out_ls_valid = !rst && tag_v[LOAD_LATENCY-1] && !tag_own[LOAD_LATENCY-1];
   assign out_io_valid = !rst && tag_v[LOAD_LATENCY-1] &&  tag_own[LOAD_LATENCY-1];

   assign bus.ls_gnt    = sel_ls;
   assign bus.io_gnt    = sel_io;
   assign bus.stall_mem = !rst && bus.ls_req && !sel_ls;

   assign bus.mem_en    = sel_ls || sel_io;
   assign bus.mem_we    = we_sel;
   assign bus.mem_addr  = addr_sel;
   assign bus.mem_wdata = wdata_sel;

   assign bus.ls_rvalid = out_ls_valid;
   assign bus.io_rvalid = out_io_valid;
   assign bus.ls_rdata  = out_ls_valid ? bus.mem_rdata : '0;
   assign bus.io_rdata  = out_io_valid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int SL = 8;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if bus_a ();
   mem_port_arbiter_if bus_b ();

   mem_port_arbiter #(.LOAD_LATENCY(2), .ADDR_W(20), .DATA_W(64), .STARVE_LIMIT(SL)) u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   mem_port_arbiter #(.LOAD_LATENCY(3), .ADDR_W(20), .DATA_W(64), .STARVE_LIMIT(SL)) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   // BRAM contents as a fixed function of address.
   function automatic logic [63:0] mem_word(input logic [19:0] addr);
      if (addr == 20'h10) return 64'h0000_0000_DEAD_BEEF;
      return {32'hCAFE_0000, 12'h000, addr};
   endfunction

   logic [63:0] rd_a [2];
   logic [63:0] rd_b [3];

   always @(posedge clk) begin
      rd_a[0] <= (bus_a.mem_en && !bus_a.mem_we) ? mem_word(bus_a.mem_addr) : 64'h0;
      rd_a[1] <= rd_a[0];
      rd_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_word(bus_b.mem_addr) : 64'h0;
      rd_b[1] <= rd_b[0];
      rd_b[2] <= rd_b[1];
   end

   assign bus_a.mem_rdata = rd_a[1];
   assign bus_b.mem_rdata = rd_b[2];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a;
      bus_a.ls_req = 1'b0;
      bus_a.io_req = 1'b0;
      bus_a.ls_we  = 1'b0;
      bus_a.io_we  = 1'b0;
   endtask

   task automatic test_reset;
      logic [8:0] ctl;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ctl = {bus_a.ls_gnt, bus_a.io_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.ls_rvalid,
                bus_a.io_rvalid, bus_a.stall_mem, bus_b.ls_gnt, bus_b.io_gnt};
         tests_run++;
         if (ctl !== 9'b0) begin
            fails++;
            $display("FAIL reset_ctl cycle %0d: got %b want 000000000", i, ctl);
         end
         tests_run++;
         if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.ls_rdata, bus_a.io_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_data cycle %0d: addr %h wdata %h ls_rdata %h io_rdata %h want 0",
                     i, bus_a.mem_addr, bus_a.mem_wdata, bus_a.ls_rdata, bus_a.io_rdata);
         end
      end
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus_a.ls_gnt, bus_a.io_gnt, bus_a.stall_mem} !== 3'b100) begin
         fails++;
         $display("FAIL reset_release: ls_gnt/io_gnt/stall got %b want 100",
                  {bus_a.ls_gnt, bus_a.io_gnt, bus_a.stall_mem});
      end
      tick();
      idle_a();
      repeat (4) tick();
   endtask

   task automatic test_ls_read;
      bus_a.ls_req  = 1'b1;
      bus_a.ls_we   = 1'b0;
      bus_a.ls_addr = 20'h10;
      @(negedge clk);
      tests_run++;
      if ({bus_a.ls_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.stall_mem} !== 4'b1100 ||
          bus_a.mem_addr !== 20'h10) begin
         fails++;
         $display("FAIL ls_read_grant: gnt/en/we/stall %b addr %h want 1100 addr 00010",
                  {bus_a.ls_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.stall_mem}, bus_a.mem_addr);
      end
      tick();
      bus_a.ls_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus_a.ls_rvalid !== 1'b0 || bus_a.mem_en !== 1'b0) begin
         fails++;
         $display("FAIL ls_read_early: ls_rvalid %b mem_en %b want 0 0", bus_a.ls_rvalid, bus_a.mem_en);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus_a.ls_rvalid !== 1'b1 || bus_a.io_rvalid !== 1'b0 ||
          bus_a.ls_rdata !== 64'hDEAD_BEEF) begin
         fails++;
         $display("FAIL ls_read_return: ls_rvalid %b io_rvalid %b ls_rdata %h want 1 0 00000000deadbeef",
                  bus_a.ls_rvalid, bus_a.io_rvalid, bus_a.ls_rdata);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus_a.ls_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL ls_read_width: ls_rvalid %b want 0", bus_a.ls_rvalid);
      end
      tick();
   endtask

   task automatic test_io_write;
      bus_a.io_req   = 1'b1;
      bus_a.io_we    = 1'b1;
      bus_a.io_addr  = 20'h55;
      bus_a.io_wdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      tests_run++;
      if ({bus_a.io_gnt, bus_a.ls_gnt, bus_a.mem_en, bus_a.mem_we} !== 4'b1011 ||
          bus_a.mem_addr !== 20'h55 || bus_a.mem_wdata !== 64'h0123_4567_89AB_CDEF) begin
         fails++;
         $display("FAIL io_write: gnt/lsgnt/en/we %b addr %h wdata %h want 1011 00055 0123456789abcdef",
                  {bus_a.io_gnt, bus_a.ls_gnt, bus_a.mem_en, bus_a.mem_we},
                  bus_a.mem_addr, bus_a.mem_wdata);
      end
      tick();
      idle_a();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({bus_a.ls_rvalid, bus_a.io_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL io_write_noresp cycle %0d: rvalids %b want 00", i,
                     {bus_a.ls_rvalid, bus_a.io_rvalid});
         end
         tick();
      end
   endtask

   task automatic test_contention;
      logic exp_io;
      int   ncyc;
`ifdef MEM_ARB_FAIR_EN
      ncyc = 20;
`else
      ncyc = 50;
`endif
      bus_a.ls_req  = 1'b1;
      bus_a.ls_we   = 1'b0;
      bus_a.ls_addr = 20'h1;
      bus_a.io_req  = 1'b1;
      bus_a.io_we   = 1'b0;
      bus_a.io_addr = 20'h2;
      for (int c = 1; c <= ncyc; c++) begin
`ifdef MEM_ARB_FAIR_EN
         exp_io = ((c % (SL + 1)) == 0);
`else
         exp_io = 1'b0;
`endif
         @(negedge clk);
         tests_run++;
         if ({bus_a.io_gnt, bus_a.ls_gnt, bus_a.stall_mem} !== {exp_io, ~exp_io, exp_io}) begin
            fails++;
            $display("FAIL contention cycle %0d: io_gnt/ls_gnt/stall %b want %b", c,
                     {bus_a.io_gnt, bus_a.ls_gnt, bus_a.stall_mem}, {exp_io, ~exp_io, exp_io});
         end
         tick();
      end
      idle_a();
      repeat (4) tick();
   endtask

   task automatic test_back_to_back;
      logic        e_lsg, e_iog, e_lsv, e_iov;
      logic [63:0] e_lsd, e_iod;
      bus_a.ls_we   = 1'b0;
      bus_a.io_we   = 1'b0;
      bus_a.io_addr = 20'h32;
      for (int i = 0; i < 6; i++) begin
         bus_a.ls_req  = (i == 0 || i == 2);
         bus_a.ls_addr = (i == 0) ? 20'h21 : 20'h43;
         bus_a.io_req  = (i == 1);
         e_lsg = (i == 0 || i == 2);
         e_iog = (i == 1);
         e_lsv = (i == 2 || i == 4);
         e_iov = (i == 3);
         e_lsd = (i == 2) ? mem_word(20'h21) : (i == 4) ? mem_word(20'h43) : 64'h0;
         e_iod = (i == 3) ? mem_word(20'h32) : 64'h0;
         @(negedge clk);
         tests_run++;
         if ({bus_a.ls_gnt, bus_a.io_gnt, bus_a.ls_rvalid, bus_a.io_rvalid} !==
             {e_lsg, e_iog, e_lsv, e_iov} ||
             bus_a.ls_rdata !== e_lsd || bus_a.io_rdata !== e_iod) begin
            fails++;
            $display("FAIL back_to_back cycle %0d: gnt/rv %b ls_rdata %h io_rdata %h want %b %h %h", i,
                     {bus_a.ls_gnt, bus_a.io_gnt, bus_a.ls_rvalid, bus_a.io_rvalid},
                     bus_a.ls_rdata, bus_a.io_rdata, {e_lsg, e_iog, e_lsv, e_iov}, e_lsd, e_iod);
         end
         tick();
      end
      idle_a();
   endtask

   task automatic test_io_read_l3;
      bus_b.io_req  = 1'b1;
      bus_b.io_we   = 1'b0;
      bus_b.io_addr = 20'h7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if ({bus_b.io_gnt, bus_b.io_rvalid, bus_b.ls_rvalid} !== {i == 0, i == 3, 1'b0} ||
             bus_b.io_rdata !== ((i == 3) ? mem_word(20'h7) : 64'h0)) begin
            fails++;
            $display("FAIL io_read_l3 cycle %0d: gnt/iorv/lsrv %b io_rdata %h want %b", i,
                     {bus_b.io_gnt, bus_b.io_rvalid, bus_b.ls_rvalid}, bus_b.io_rdata,
                     {i == 0, i == 3, 1'b0});
         end
         tick();
         bus_b.io_req = 1'b0;
      end
   endtask

   task automatic test_reset_midflight;
      bus_b.io_req  = 1'b1;
      bus_b.io_we   = 1'b0;
      bus_b.io_addr = 20'h9;
      @(negedge clk);
      tests_run++;
      if (bus_b.io_gnt !== 1'b1) begin
         fails++;
         $display("FAIL midflight_grant: io_gnt %b want 1", bus_b.io_gnt);
      end
      tick();
      bus_b.io_req = 1'b0;
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tests_run++;
         if ({bus_b.io_rvalid, bus_b.ls_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL midflight_drop cycle %0d: io_rvalid/ls_rvalid %b want 00", i,
                     {bus_b.io_rvalid, bus_b.ls_rvalid});
         end
         tick();
      end
   endtask

   initial begin
      rst_a          = 1'b1;
      rst_b          = 1'b1;
      bus_a.ls_req   = 1'b1;
      bus_a.ls_we    = 1'b0;
      bus_a.ls_addr  = 20'h1;
      bus_a.ls_wdata = 64'h1111;
      bus_a.io_req   = 1'b1;
      bus_a.io_we    = 1'b0;
      bus_a.io_addr  = 20'h2;
      bus_a.io_wdata = 64'h2222;
      bus_b.ls_req   = 1'b0;
      bus_b.ls_we    = 1'b0;
      bus_b.ls_addr  = 20'h0;
      bus_b.ls_wdata = 64'h0;
      bus_b.io_req   = 1'b0;
      bus_b.io_we    = 1'b0;
      bus_b.io_addr  = 20'h0;
      bus_b.io_wdata = 64'h0;

      test_reset();
      test_ls_read();
      test_io_write();
      test_contention();
      test_back_to_back();
      test_io_read_l3();
      test_reset_midflight();

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
